// File: rtl/wl_arb_pkg.sv
// Shared types and helpers for the round-robin weight-loader arbiter.
package wl_arb_pkg;

  // Largest channel count the one-hot helper covers.
  localparam int unsigned MAX_CH = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Index width for an n-entry pointer, never below one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One-hot vector with bit idx set; callers truncate to their channel count.
  function automatic logic [MAX_CH-1:0] onehot_max(input int unsigned idx);
    return MAX_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/wl_rr_picker.sv
// Combinational round-robin picker: first set request after last owner.
module wl_rr_picker
  import wl_arb_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  localparam int unsigned PTR_W = ptr_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] last,
  output logic [N_CH-1:0]  pick,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int unsigned      c;
  logic [PTR_W-1:0] ci;

  // Scan channels last+1 .. last+N_CH (mod N_CH); the first hit wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    c    = 0;
    ci   = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      c = 32'(last) + k;
      if (c >= N_CH) c = c - N_CH;
      ci = PTR_W'(c);
      if (!any && req[ci]) begin
        any  = 1'b1;
        idx  = ci;
        pick = N_CH'(onehot_max(c));
      end
    end
  end

endmodule

// File: rtl/weight_loader_arbiter_rr.sv
// N-channel round-robin arbiter for one shared weight loader, with stream demux,
// beat-count checking and a stall watchdog.
module weight_loader_arbiter_rr
  import wl_arb_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned CNT_W   = 17,
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*ADDR_W-1:0]   req_base,
  input  logic [N_CH*CNT_W-1:0]    req_count,
  output logic [N_CH-1:0]          grant,
  output logic [N_CH-1:0]          out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [N_CH-1:0]          done,
  output logic                     err_len,
  output logic                     err_tmo,
  output logic                     ldr_start,
  output logic [ADDR_W-1:0]        ldr_base,
  output logic [CNT_W-1:0]         ldr_count,
  input  logic                     ldr_valid,
  input  logic [DATA_W-1:0]        ldr_data,
  input  logic                     ldr_done
);

  localparam int unsigned PTR_W  = ptr_w(N_CH);
  localparam int unsigned BCNT_W = CNT_W + 1;
  localparam int unsigned TW1    = TMO_W + 1;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ch_q, ch_d, last_q, last_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BCNT_W-1:0]   beats_q, beats_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                tmo_hit;

  logic [N_CH-1:0]     grant_q, grant_d;
  logic [N_CH-1:0]     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [N_CH-1:0]     done_q, done_d;
  logic                err_len_q, err_len_d;
  logic                err_tmo_q, err_tmo_d;
  logic                ldr_start_q, ldr_start_d;

  logic [N_CH-1:0]     pick_oh;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic [N_CH-1:0]     ch_oh;

  logic [ADDR_W-1:0]   base_arr  [N_CH];
  logic [CNT_W-1:0]    count_arr [N_CH];

  // Per-channel views of the flattened base/count buses.
  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign base_arr[i]  = req_base[i*ADDR_W +: ADDR_W];
    assign count_arr[i] = req_count[i*CNT_W +: CNT_W];
  end

  wl_rr_picker #(.N_CH(N_CH)) u_picker (
    .req  (req),
    .last (last_q),
    .pick (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign ch_oh = N_CH'(onehot_max(32'(ch_q)));

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    last_d      = last_q;
    base_d      = base_q;
    count_d     = count_q;
    beats_d     = beats_q;
    tmo_d       = tmo_q;
    tmo_hit     = 1'b0;
    grant_d     = grant_q;
    out_valid_d = '0;
    out_data_d  = out_data_q;
    done_d      = '0;
    err_len_d   = 1'b0;
    err_tmo_d   = 1'b0;
    ldr_start_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (pick_any) begin
          ch_d    = pick_idx;
          base_d  = base_arr[pick_idx];
          count_d = count_arr[pick_idx];
          beats_d = '0;
          tmo_d   = '0;
          grant_d = pick_oh;
          if (count_arr[pick_idx] != '0) begin
            state_d     = S_START;
            ldr_start_d = 1'b1;
          end else begin
            // Zero-length request completes without touching the loader.
            state_d = S_DONE;
            done_d  = pick_oh;
          end
        end
      end

      S_START: begin
        state_d = S_STREAM;
      end

      S_STREAM: begin
        if (ldr_valid) begin
          out_valid_d = ch_oh;
          out_data_d  = ldr_data;
          if (beats_q != '1) beats_d = beats_q + BCNT_W'(1);
        end
        if (ldr_valid || ldr_done) begin
          tmo_d = '0;
        end else if (TMO_CYC != 0) begin
          tmo_d   = tmo_q + TMO_W'(1);
          tmo_hit = (TW1'(tmo_q) + TW1'(1)) == TW1'(TMO_CYC);
        end
        if (ldr_done) begin
          state_d   = S_DONE;
          done_d    = ch_oh;
          err_len_d = (beats_d != {1'b0, count_q});
        end else if (tmo_hit) begin
          state_d   = S_DONE;
          done_d    = ch_oh;
          err_tmo_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        last_d  = ch_q;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, transfer latches and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      last_q      <= PTR_W'(N_CH - 1);
      base_q      <= '0;
      count_q     <= '0;
      beats_q     <= '0;
      tmo_q       <= '0;
      grant_q     <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      done_q      <= '0;
      err_len_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      ldr_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      last_q      <= last_d;
      base_q      <= base_d;
      count_q     <= count_d;
      beats_q     <= beats_d;
      tmo_q       <= tmo_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
      err_tmo_q   <= err_tmo_d;
      ldr_start_q <= ldr_start_d;
    end
  end

  assign grant     = grant_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign err_len   = err_len_q;
  assign err_tmo   = err_tmo_q;
  assign ldr_start = ldr_start_q;
  assign ldr_base  = base_q;
  assign ldr_count = count_q;

endmodule
